// File: rtl/scope_pkg.sv
// scope_pkg: shared types and constants for the scope acquisition path.
//   state_t  - acquisition sequencer states
//   MODE_*   - encodings of the 2-bit capture mode input (3 behaves as normal)
//   SAMPLE_W - ADC sample width
package scope_pkg;
  localparam int SAMPLE_W = 12;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRETRIG = 3'd1,
    ARMED   = 3'd2,
    POST    = 3'd3,
    HOLD    = 3'd4
  } state_t;

  localparam logic [1:0] MODE_AUTO   = 2'd0;
  localparam logic [1:0] MODE_NORMAL = 2'd1;
  localparam logic [1:0] MODE_SINGLE = 2'd2;
endpackage

// File: rtl/trig_detect.sv
// trig_detect: level/edge trigger comparator.
//   CLK, RSTB     - clock, async active-low reset
//   clr           - forget the previous sample (start of a new capture)
//   sample_valid  - new sample strobe
//   sample        - current sample
//   level         - threshold
//   falling       - 0 = rising crossing, 1 = falling crossing
//   hit           - combinational, high in the cycle of the crossing sample
module trig_detect
  import scope_pkg::*;
(
  input  logic                CLK,
  input  logic                RSTB,
  input  logic                clr,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [SAMPLE_W-1:0] level,
  input  logic                falling,
  output logic                hit
);
  logic [SAMPLE_W-1:0] prev;
  logic                prev_valid;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (clr) begin
      // a sample arriving on the clear cycle is never captured, so drop it too
      prev_valid <= 1'b0;
    end else if (sample_valid) begin
      prev       <= sample;
      prev_valid <= 1'b1;
    end
  end

  always_comb begin
    hit = 1'b0;
    if (sample_valid && prev_valid) begin
      if (falling) hit = (prev >= level) && (sample <  level);
      else         hit = (prev <  level) && (sample >= level);
    end
  end
endmodule

// File: rtl/acq_controller.sv
// acq_controller: acquisition sequencer for the scope sample buffer.
// Fills a circular buffer with ADC samples, keeps PRE_TRIG samples ahead of
// the trigger, freezes the buffer once a frame is complete and hands it to
// the display via frame_valid/frame_ack.
//   CLK, RSTB                 - clock, async active-low reset
//   sample_valid, sample      - ADC sample stream
//   trig_level, trig_edge     - trigger threshold and slope (1 = falling)
//   mode                      - 0 auto, 1 normal, 2 single, 3 normal
//   arm                       - starts a single-shot capture from IDLE
//   frame_ack                 - display has consumed the frozen frame
//   wr_en, wr_addr, wr_data   - registered buffer write port
//   frame_valid, frame_start  - frozen frame and address of its oldest sample
//   forced                    - frame was produced by the auto timeout
//   busy                      - capture in progress (not IDLE, not HOLD)
module acq_controller
  import scope_pkg::*;
#(
  parameter int DEPTH        = 640,
  parameter int ADDR_W       = 10,
  parameter int PRE_TRIG     = 64,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic                CLK,
  input  logic                RSTB,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                trig_edge,
  input  logic [1:0]          mode,
  input  logic                arm,
  input  logic                frame_ack,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [SAMPLE_W-1:0] wr_data,
  output logic                frame_valid,
  output logic [ADDR_W-1:0]   frame_start,
  output logic                forced,
  output logic                busy
);
  localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(DEPTH - PRE_TRIG - 2);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PRE_OFF   = ADDR_W'(PRE_TRIG);
  localparam logic [ADDR_W-1:0] WRAP_OFF  = ADDR_W'(DEPTH - PRE_TRIG);
  localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(AUTO_TIMEOUT);

  state_t            state, next;
  logic [ADDR_W-1:0] waddr;     // address the next accepted sample goes to
  logic [ADDR_W-1:0] cnt;       // writes done in PRETRIG / POST
  logic [TO_W-1:0]   to_cnt, to_next;
  logic              wr_go, trig, force_t, clr, hit;

  trig_detect u_trig (
    .CLK          (CLK),
    .RSTB         (RSTB),
    .clr          (clr),
    .sample_valid (sample_valid),
    .sample       (sample),
    .level        (trig_level),
    .falling      (trig_edge),
    .hit          (hit)
  );

  assign to_next = (to_cnt == TO_MAX) ? to_cnt : to_cnt + 1'b1;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next    = state;
    wr_go   = 1'b0;
    trig    = 1'b0;
    force_t = 1'b0;
    case (state)
      IDLE:    if (mode != MODE_SINGLE || arm) next = PRETRIG;
      PRETRIG: if (sample_valid) begin
        wr_go = 1'b1;
        if (cnt == PRE_LAST) next = ARMED;
      end
      ARMED:   if (sample_valid) begin
        wr_go = 1'b1;
        // a real crossing wins over the timeout on the same sample
        if (hit) begin
          trig = 1'b1;
        end else if (mode == MODE_AUTO && to_next == TO_MAX) begin
          trig    = 1'b1;
          force_t = 1'b1;
        end
        if (trig) next = POST;
      end
      POST:    if (sample_valid) begin
        wr_go = 1'b1;
        if (cnt == POST_LAST) next = HOLD;
      end
      HOLD:    if (frame_ack) next = (mode == MODE_SINGLE) ? IDLE : PRETRIG;
      default: next = IDLE;
    endcase
    clr = (next == PRETRIG) && (state != PRETRIG);
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      waddr       <= '0;
      cnt         <= '0;
      to_cnt      <= '0;
      frame_start <= '0;
      forced      <= 1'b0;
    end else begin
      wr_en <= wr_go;
      if (wr_go) begin
        wr_addr <= waddr;
        wr_data <= sample;
        waddr   <= (waddr == ADDR_LAST) ? '0 : waddr + 1'b1;
      end
      if (next != state) cnt <= '0;
      else if (wr_go)    cnt <= cnt + 1'b1;
      if (state != ARMED)    to_cnt <= '0;
      else if (sample_valid) to_cnt <= to_next;
      // the trigger sample sits at waddr; step back PRE_TRIG without
      // letting the ADDR_W-bit sum pass DEPTH
      if (trig) begin
        frame_start <= (waddr >= PRE_OFF) ? waddr - PRE_OFF : waddr + WRAP_OFF;
        forced      <= force_t;
      end
    end
  end

  assign frame_valid = (state == HOLD);
  assign busy        = (state != IDLE) && (state != HOLD);
endmodule

// File: tb/tb_acq_controller.sv
module tb_acq_controller;
  localparam int DEPTH = 640, ADDR_W = 10, PRE = 64, AUTO = 4096;
  localparam int POST_N = DEPTH - PRE - 1;

  logic              CLK = 1'b0;
  logic              RSTB = 1'b0;
  logic              sample_valid = 1'b0;
  logic [11:0]       sample = '0;
  logic [11:0]       trig_level = 12'd2048;
  logic              trig_edge = 1'b0;
  logic [1:0]        mode = 2'd1;
  logic              arm = 1'b0;
  logic              frame_ack = 1'b0;
  logic              wr_en, frame_valid, forced, busy;
  logic [ADDR_W-1:0] wr_addr, frame_start;
  logic [11:0]       wr_data;

  acq_controller #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .PRE_TRIG(PRE), .AUTO_TIMEOUT(AUTO)) dut (
    .CLK(CLK), .RSTB(RSTB), .sample_valid(sample_valid), .sample(sample),
    .trig_level(trig_level), .trig_edge(trig_edge), .mode(mode), .arm(arm),
    .frame_ack(frame_ack), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_valid(frame_valid), .frame_start(frame_start), .forced(forced), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0, n_err = 0;

  // capture-level model: a capture is a count of accepted samples; the
  // trigger is the index of the crossing sample; the frame is done once
  // POST_N samples follow it
  int m_active, m_n, m_trig, m_prev, m_prevv, m_armed, m_next;
  int exp_en, exp_addr, exp_data, exp_fv, exp_fs, exp_forced, exp_busy;

  // monitors on the DUT write stream
  int wcount, last_addr, saw_wrap, fv_seen;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_n = 0; m_trig = -1; m_prev = 0; m_prevv = 0; m_armed = 0; m_next = 0;
    exp_en = 0; exp_addr = 0; exp_data = 0; exp_fv = 0; exp_fs = 0; exp_forced = 0; exp_busy = 0;
  endtask

  task automatic start_capture();
    m_active = 1; m_n = 0; m_trig = -1; m_prevv = 0; m_armed = 0;
  endtask

  function automatic int frame_done();
    return (m_active != 0 && m_trig >= 0 && m_n == m_trig + 1 + POST_N) ? 1 : 0;
  endfunction

  task automatic model_step();
    int s, lvl, crossed;
    exp_en = 0;
    if (!RSTB) begin model_reset(); return; end
    s = int'(sample); lvl = int'(trig_level);
    if (m_active == 0) begin
      if (mode != 2'd2 || arm) start_capture();
    end else if (frame_done() != 0) begin
      if (frame_ack) begin
        if (mode == 2'd2) m_active = 0;
        else start_capture();
      end
    end else if (sample_valid) begin
      exp_en = 1; exp_addr = m_next; exp_data = s;
      m_next = (m_next + 1) % DEPTH;
      if (m_n >= PRE && m_trig < 0) begin
        if (m_armed < AUTO) m_armed++;
        crossed = 0;
        if (m_prevv != 0) begin
          if (trig_edge) crossed = (m_prev >= lvl && s < lvl) ? 1 : 0;
          else           crossed = (m_prev < lvl && s >= lvl) ? 1 : 0;
        end
        if (crossed != 0 || (mode == 2'd0 && m_armed >= AUTO)) begin
          m_trig = m_n;
          exp_forced = (crossed != 0) ? 0 : 1;
          exp_fs = (exp_addr + DEPTH - PRE) % DEPTH;
        end
      end
      m_prev = s; m_prevv = 1; m_n++;
    end
    exp_fv = frame_done();
    exp_busy = (m_active != 0 && exp_fv == 0) ? 1 : 0;
  endtask

  task automatic compare();
    check("wr_en", int'(wr_en), exp_en);
    check("wr_addr", int'(wr_addr), exp_addr);
    check("wr_data", int'(wr_data), exp_data);
    check("frame_valid", int'(frame_valid), exp_fv);
    check("frame_start", int'(frame_start), exp_fs);
    check("forced", int'(forced), exp_forced);
    check("busy", int'(busy), exp_busy);
    if (wr_en) begin
      wcount++;
      if (wr_addr == '0 && last_addr == DEPTH - 1) saw_wrap = 1;
      last_addr = int'(wr_addr);
    end
    if (frame_valid) fv_seen = 1;
  endtask

  task automatic tick();
    @(posedge CLK); model_step();
    @(negedge CLK); compare();
  endtask

  task automatic feed(input int v);
    sample_valid = 1'b1; sample = 12'(v);
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic ack(input logic [1:0] m);
    mode = m; frame_ack = 1'b1; sample_valid = 1'b1; sample = 12'd123;
    tick();
    frame_ack = 1'b0; sample_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    wcount = 0; last_addr = 0; saw_wrap = 0; fv_seen = 0;
    repeat (3) tick();
    RSTB = 1'b1;
    tick();  // IDLE -> PRETRIG in normal mode

    // 1: rising ramp, normal mode, trigger on 2048
    wcount = 0;
    for (int k = 0; k < 2000 && !frame_valid; k++) feed((8 * k) % 4096);
    check("t1_frame_valid", int'(frame_valid), 1);
    check("t1_frame_start", int'(frame_start), 192);
    check("t1_writes", wcount, 832);
    check("t1_forced", int'(forced), 0);
    check("t1_last_addr", int'(wr_addr), 191);

    // 2: constant input, auto mode -> forced after 4096 armed samples
    ack(2'd0);
    check("t2_ack_fv", int'(frame_valid), 0);
    check("t2_ack_busy", int'(busy), 1);
    wcount = 0;
    for (int k = 0; k < 6000 && !frame_valid; k++) feed(1000);
    check("t2_frame_valid", int'(frame_valid), 1);
    check("t2_forced", int'(forced), 1);
    check("t2_frame_start", int'(frame_start), 447);
    check("t2_writes", wcount, 4735);

    // 3: same input, normal mode -> never a frame
    ack(2'd1);
    fv_seen = 0;
    for (int k = 0; k < 10000; k++) feed(1000);
    check("t3_no_frame", fv_seen, 0);
    check("t3_forced_kept", int'(forced), 1);
    check("t3_busy", int'(busy), 1);

    // 4: falling edge on a square wave; the 500->3000 step must not fire
    trig_edge = 1'b1; trig_level = 12'd1500;
    wcount = 0;
    for (int k = 0; k < 2000 && !frame_valid; k++) feed(((k % 4) < 2) ? 500 : 3000);
    check("t4_frame_valid", int'(frame_valid), 1);
    check("t4_frame_start", int'(frame_start), 147);
    check("t4_writes", wcount, 580);
    check("t4_forced", int'(forced), 0);

    // 5: trigger just after the address wrap
    trig_edge = 1'b0; trig_level = 12'd2048;
    ack(2'd1);
    wcount = 0; saw_wrap = 0;
    for (int k = 0; k < 3000 && !frame_valid; k++) feed((k >= 513) ? 4000 : 0);
    check("t5_frame_valid", int'(frame_valid), 1);
    check("t5_frame_start", int'(frame_start), 596);
    check("t5_wrap", saw_wrap, 1);
    check("t5_writes", wcount, 1089);

    // 6: single shot
    ack(2'd2);
    check("t6_idle_busy", int'(busy), 0);
    check("t6_idle_fv", int'(frame_valid), 0);
    wcount = 0;
    for (int k = 0; k < 20; k++) feed(500);
    check("t6_no_writes", wcount, 0);
    arm = 1'b1; tick(); arm = 1'b0;
    check("t6_armed_busy", int'(busy), 1);
    wcount = 0;
    for (int k = 0; k < 2000 && !frame_valid; k++) feed((8 * k) % 4096);
    check("t6_frame_valid", int'(frame_valid), 1);
    check("t6_frame_start", int'(frame_start), 148);
    check("t6_writes", wcount, 832);
    ack(2'd2);
    check("t6_back_idle", int'(busy), 0);
    wcount = 0;
    for (int k = 0; k < 20; k++) feed(700);
    check("t6_no_writes2", wcount, 0);
    arm = 1'b1; tick(); arm = 1'b0;
    check("t6_rearm_busy", int'(busy), 1);
    feed(0);
    check("t6_rearm_write", wcount, 1);

    // 7: reset in the middle of POST
    mode = 2'd1;
    for (int k = 1; k <= 266; k++) feed((8 * k) % 4096);
    check("t7_in_post_busy", int'(busy), 1);
    check("t7_in_post_fv", int'(frame_valid), 0);
    #2 RSTB = 1'b0;
    #1;
    model_reset();
    check("t7_rst_wr_en", int'(wr_en), 0);
    check("t7_rst_wr_addr", int'(wr_addr), 0);
    check("t7_rst_wr_data", int'(wr_data), 0);
    check("t7_rst_fv", int'(frame_valid), 0);
    check("t7_rst_fs", int'(frame_start), 0);
    check("t7_rst_forced", int'(forced), 0);
    check("t7_rst_busy", int'(busy), 0);
    @(negedge CLK);
    RSTB = 1'b1;
    tick();
    feed(777);
    check("t7_first_en", int'(wr_en), 1);
    check("t7_first_addr", int'(wr_addr), 0);
    check("t7_first_data", int'(wr_data), 777);
    for (int k = 0; k < 5; k++) feed(100 + k);
    check("t7_addr_after", int'(wr_addr), 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/acq_controller.md
# acq_controller

Acquisition sequencer for the scope sample buffer. It takes the 12-bit ADC sample stream, fills a circular capture buffer, and detects level and edge triggers with a programmable pre-trigger depth. Once a frame is complete it freezes the buffer and hands the frame to the display path through a valid/ack handshake. It sits between the ADC front end and the sample buffer/VGA readout, and replaces free-running buffer writes with auto, normal and single-shot capture.

## Interface
Parameters:
- DEPTH, 640: samples per frame (screen width); buffer address range 0..DEPTH-1
- ADDR_W, 10: address width; must satisfy 2^ADDR_W >= DEPTH
- PRE_TRIG, 64: samples kept before the trigger point; must be < DEPTH
- AUTO_TIMEOUT, 4096: samples spent in ARMED before auto mode forces a trigger

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  system clock; all logic on posedge
- RSTB  in  1  asynchronous active-low reset
- sample_valid  in  1  one-cycle strobe: a new ADC sample is present
- sample  in  12  unsigned ADC code
- trig_level  in  12  trigger threshold, read on every compare
- trig_edge  in  1  0 = rising, 1 = falling
- mode  in  2  0 = auto, 1 = normal, 2 = single; 3 is treated as normal
- arm  in  1  pulse that starts a single-shot capture
- frame_ack  in  1  pulse from display: frame has been consumed
- wr_en  out  1  buffer write strobe
- wr_addr  out  ADDR_W  buffer write address
- wr_data  out  12  buffer write data
- frame_valid  out  1  a complete frame is frozen in the buffer
- frame_start  out  ADDR_W  buffer address of the oldest sample in the frame
- forced  out  1  the current or last frame was auto-forced, not a real trigger
- busy  out  1  state is not IDLE and not HOLD

## Operation
States and transitions:
- IDLE: leave on reset release to PRETRIG if mode != single. In single mode, go to PRETRIG on `arm`.
- PRETRIG: write each valid sample. After PRE_TRIG writes go to ARMED. Triggers are ignored in this state.
- ARMED: write each valid sample and count samples (`to_cnt`). A trigger occurs on a valid sample when prev_valid is set and:
  - rising: prev < trig_level and sample >= trig_level
  - falling: prev >= trig_level and sample < trig_level
- ARMED, on trigger: latch trig_addr = address of the current sample, clear `forced`, go to POST.
- ARMED, auto timeout: in auto mode, when to_cnt reaches AUTO_TIMEOUT, treat the current sample as the trigger, set `forced`, go to POST.
- POST: write DEPTH-PRE_TRIG-1 further samples, then go to HOLD. The frame is the trigger sample plus PRE_TRIG samples before it and DEPTH-PRE_TRIG-1 samples after it.
- HOLD: no writes; frame_valid=1. On frame_ack, go to IDLE if mode == single, otherwise to PRETRIG.

Rules:
- frame_start = (trig_addr + DEPTH - PRE_TRIG) mod DEPTH, computed without overflow of ADDR_W.
- wr_addr increments once per write and wraps DEPTH-1 -> 0. It is not reset on re-arm.
- prev/prev_valid: prev_valid is cleared on entry to PRETRIG and set by the first valid sample. prev holds the last valid sample.
- to_cnt is cleared on entry to ARMED and saturates at AUTO_TIMEOUT.
- `mode` is sampled only at the IDLE/HOLD exits and at the timeout check. A change during PRETRIG/POST has no effect on the frame in progress.
- `arm` outside IDLE, or in IDLE when mode != single, is ignored.
- frame_ack outside HOLD is ignored.
- A sample_valid in the same cycle as frame_ack in HOLD is dropped, not written.

## Timing
- Reset values: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, frame_valid=0, frame_start=0, forced=0, busy=0, all counters=0.
- wr_en/wr_addr/wr_data are registered, 1 cycle after the qualifying sample_valid. wr_en is high for exactly one cycle per accepted sample.
- Trigger decision is made in the cycle of sample_valid; the state change is visible the next cycle.
- frame_valid rises 1 cycle after the final POST write is issued, i.e. in the same cycle that the last wr_en is high. frame_start is stable while frame_valid=1.
- frame_ack pulse -> frame_valid=0 next cycle; state is PRETRIG/IDLE in that same cycle.
- Back-to-back sample_valid on every cycle must be supported.
- RSTB assertion mid-capture returns everything to reset values immediately (asynchronous). The partial frame is discarded.

## Structure
- Shared package scope_pkg: state enum (IDLE, PRETRIG, ARMED, POST, HOLD), mode encodings, and SAMPLE_W=12.
- One sub-module, trig_detect: prev register, prev_valid, and the edge compare. Output is a one-cycle `hit`.
- Address wrap and frame_start arithmetic stay in acq_controller.

## Test plan
- Ramp 0..4095 step 8, rising edge, level 2048, normal mode -> trigger on sample 2048. Exactly 64 writes precede it and 575 follow. frame_start = trig_addr - 64 mod 640. forced=0.
- Constant input 1000, level 2048, auto mode -> forced trigger after 4096 ARMED samples. frame_valid=1, forced=1. Same input in normal mode -> no frame_valid after 10000 samples.
- Falling edge, square wave 3000/500, level 1500 -> trigger only on 3000->500 transitions, never on 500->3000.
- Single mode: no writes before `arm`. After one frame plus frame_ack -> IDLE, busy=0. A second frame only follows a second `arm`.
- Wrap: start wr_addr at 600 (run prior frames). Capture -> addresses go 639 -> 0, and frame_start is computed correctly across the wrap.
- RSTB pulse during POST -> all outputs at reset values that cycle. Capture restarts from PRETRIG with wr_addr=0.
